load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit directly downstream of the EX-stage ALU. Takes the ALU result as the byte address.
//  Runs one data-memory transaction per instruction over a req/ack bus, with byte-lane steering for stores and
//  sign/zero extension for loads. Stalls the pipeline until the access completes. Flags misaligned/illegal
//  accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYC  256  REQ cycles without mem_ack before the access is abandoned (>=2)
//  CNT_W        9    width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  ex_valid       in   1   memory instruction present at stage input
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store (wins if both high)
//  ex_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_addr        in   32  byte address (ALU result)
//  ex_wdata       in   32  store data (forwarded rs2)
//  lsu_stall      out  1   hold all upstream stages this cycle
//  ld_valid       out  1   one-cycle pulse; ld_data valid
//  ld_data        out  32  extended load result
//  exc_misalign   out  1   one-cycle pulse: misaligned or illegal funct3
//  exc_bus        out  1   one-cycle pulse: timeout
//  mem_req        out  1   bus request
//  mem_we         out  1   1 = write
//  mem_addr       out  32  word address, {ex_addr[31:2],2'b00}
//  mem_be         out  4   byte enables
//  mem_wdata      out  32  lane-replicated store data
//  mem_ack        in   1   transaction complete; mem_rdata valid (reads)
//  mem_rdata      in   32  read word
// BEHAVIOUR
//  States: IDLE, REQ, RESP. Reset (async, reset_n=0): state=IDLE; every registered output = 0; mem_req drops immediately.
//  IDLE, accept = ex_valid & (ex_mem_read|ex_mem_write):
//  - lsu_stall=1 (combinational).
//  - Legal & aligned: register addr/be/wdata/we, mem_req<=1, go to REQ.
//  - Misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or funct3 in {011,110,111}: no bus request; go to RESP with
//    exc_misalign=1. Stores never write.
//  REQ: lsu_stall=1. mem_req/we/addr/be/wdata held stable until mem_ack is sampled high.
//  - On ack: mem_req<=0. Loads capture the extended result into ld_data. Go to RESP.
//  - Timeout counter starts at 0 on entry and increments per REQ cycle without ack. At TIMEOUT_CYC-1 with no ack:
//    mem_req<=0, ld_data<=0, exc_bus<=1, go to RESP. Ack in the same cycle as expiry wins (normal completion).
//  RESP (exactly 1 cycle): lsu_stall=0; ld_valid=1 only for successful loads; exc_* pulses here. Pipeline
//    advances at end of RESP. ex_valid seen during RESP is the completing op: ignored. Always go to IDLE.
//  Latency: ack on first REQ cycle gives accept->RESP = 2 cycles (3-cycle op). Misaligned op = 2 cycles.
//  mem_ack outside REQ is ignored (late ack after timeout).
//  Store lanes: SB be=0001<<a[1:0], wdata={4{d[7:0]}}; SH be=0011<<{a[1],1'b0}, wdata={2{d[15:0]}}; SW be=1111.
//  Load extract: byte=rdata[8*a[1:0]+:8], half=rdata[16*a[1]+:16]. B/H sign-extend; BU/HU zero-extend.
//  ld_data/exc hold 0 outside RESP. Not-accepted cycles in IDLE: lsu_stall=0, mem_req=0.
// STRUCTURE
//  Shared header rv32_defs.vh: funct3 load/store codes, LSU state encodings.
//  Sub-module lsu_align (combinational): funct3+addr+wdata/rdata -> be, lane data, extended load, misalign flag.
//  Top holds FSM, timeout counter, bus registers.
// TESTING
//  LW a=0x100, rdata=0xDEADBEEF, ack on 1st REQ cycle -> ld_data=0xDEADBEEF, ld_valid in cycle 3, stall cycles 1-2.
//  LB a=0x103, rdata=0x80xxxxxx -> 0xFFFFFF80; LBU -> 0x00000080; LH a=0x102, rdata=0x8001xxxx -> 0xFFFF8001.
//  SB a=0x201 d=0x000000AB -> mem_addr=0x200, be=0010, wdata=0xABABABAB, we=1, ld_valid=0.
//  SH a=0x203 -> exc_misalign pulse, mem_req never 1, 2-cycle stall; LW a=0x102 same.
//  No ack for TIMEOUT_CYC cycles -> mem_req drops, exc_bus pulse, ld_data=0; late ack next cycle ignored.
//  reset_n low mid-REQ -> mem_req, lsu_stall, outputs 0 immediately; next op after release completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 codes for the MEM-stage load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
interface load_store_unit_if;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;

    logic        lsu_stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        exc_misalign;
    logic        exc_bus;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // LSU view: serves the pipeline and masters the memory bus
    modport master (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
        input  mem_ack, mem_rdata,
        output lsu_stall, ld_valid, ld_data, exc_misalign, exc_bus,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
        output mem_ack, mem_rdata,
        input  lsu_stall, ld_valid, ld_data, exc_misalign, exc_bus,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for loads,
// and misalignment / illegal-funct3 detection.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        uns;

    assign uns = funct3_i[2];

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        ldata_o = '0;
        byte_v  = rdata_i[{addr_i, 3'b000} +: 8];
        half_v  = rdata_i[{addr_i[1], 4'b0000} +: 16];
        case (funct3_i[1:0])
            SZ_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                be_o    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_W: begin
                be_o    = '1;
                wdata_o = wdata_i;
                ldata_o = rdata_i;
            end
            default: ;
        endcase
    end

    assign misalign_o = f3_illegal(funct3_i)
                      | ((funct3_i[1:0] == SZ_H) & addr_i[0])
                      | ((funct3_i[1:0] == SZ_W) & (|addr_i));

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one req/ack data-memory transaction per instruction,
// pipeline stall while busy, misalign and bus-timeout exception pulses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    load_store_unit_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       alo_q, alo_d;
    logic             ld_valid_q, ld_valid_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             exc_mis_q, exc_mis_d;
    logic             exc_bus_q, exc_bus_d;

    logic             accept;
    logic             lsu_stall_c;
    logic [2:0]       al_f3;
    logic [1:0]       al_addr;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_ldata;
    logic             al_mis;

    assign accept = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);

    // One align unit is shared: it sees the incoming op in IDLE (store lanes,
    // misalign check) and the latched op in REQ (load extraction).
    assign al_f3   = (state_q == ST_IDLE) ? bus.ex_funct3    : f3_q;
    assign al_addr = (state_q == ST_IDLE) ? bus.ex_addr[1:0] : alo_q;

    load_store_unit_align u_align (
        .funct3_i   (al_f3),
        .addr_i     (al_addr),
        .wdata_i    (bus.ex_wdata),
        .rdata_i    (bus.mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .ldata_o    (al_ldata),
        .misalign_o (al_mis)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        is_load_d   = is_load_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = '0;
        exc_mis_d   = 1'b0;
        exc_bus_d   = 1'b0;
        lsu_stall_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lsu_stall_c = 1'b1;
                    if (al_mis) begin
                        exc_mis_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ex_mem_write;
                        mem_addr_d  = {bus.ex_addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        is_load_d   = ~bus.ex_mem_write;
                        f3_d        = bus.ex_funct3;
                        alo_d       = bus.ex_addr[1:0];
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                lsu_stall_c = 1'b1;
                if (bus.mem_ack || cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    state_d     = ST_RESP;
                    if (bus.mem_ack) begin
                        ld_valid_d = is_load_q;
                        ld_data_d  = is_load_q ? al_ldata : '0;
                    end else begin
                        exc_bus_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            is_load_q   <= 1'b0;
            f3_q        <= '0;
            alo_q       <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            is_load_q   <= is_load_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            exc_mis_q   <= exc_mis_d;
            exc_bus_q   <= exc_bus_d;
        end
    end

    assign bus.lsu_stall    = lsu_stall_c;
    assign bus.ld_valid     = ld_valid_q;
    assign bus.ld_data      = ld_data_q;
    assign bus.exc_misalign = exc_mis_q;
    assign bus.exc_bus      = exc_bus_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected bus transfers and
// responses, a memory responder and a response monitor pop and compare them.
module tb_load_store_unit;

    localparam int unsigned TO = 256;

    typedef struct {
        string       name;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        exc_mis;
        logic        exc_bus;
    } resp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wdata;
        int unsigned delay;
        logic [31:0] rdata;
        bit          no_ack;
        bit          late_ack;
        bit          abort;
    } bus_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYC(TO), .CNT_W(9)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    resp_t       resp_q[$];
    bus_t        bus_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_resp(input string name, input logic lv, input logic [31:0] d,
                             input logic mis, input logic be_x);
        resp_t r;
        r.name = name; r.ld_valid = lv; r.ld_data = d; r.exc_mis = mis; r.exc_bus = be_x;
        resp_q.push_back(r);
    endtask

    task automatic push_bus(input string name, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input int unsigned dly,
                            input logic [31:0] rd, input bit no_ack, input bit late, input bit abort);
        bus_t b;
        b.name = name; b.we = we; b.addr = a & 32'hFFFF_FFFC; b.be = be; b.wdata = wd;
        b.chk_wdata = we; b.delay = dly; b.rdata = rd; b.no_ack = no_ack;
        b.late_ack = late; b.abort = abort;
        bus_q.push_back(b);
    endtask

    task automatic do_op(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int unsigned exp_cyc);
        int unsigned cyc;
        bit          done;
        @(posedge clk); #1;
        bus.ex_valid = 1'b1; bus.ex_mem_read = rd; bus.ex_mem_write = wr;
        bus.ex_funct3 = f3; bus.ex_addr = a; bus.ex_wdata = wd;
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (!bus.lsu_stall) done = 1;
            else if (cyc > 2000) done = 1;
        end
        check({name, ".op_cycles"}, cyc, exp_cyc);
    endtask

    task automatic load(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rdata, input int unsigned dly,
                        input logic [3:0] be, input logic [31:0] exp_d);
        push_bus(name, 1'b0, a, be, '0, dly, rdata, 0, 0, 0);
        push_resp(name, 1'b1, exp_d, 1'b0, 1'b0);
        do_op(name, 1'b1, 1'b0, f3, a, 32'h5555_5555, dly + 3);
    endtask

    task automatic store(input string name, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int unsigned dly,
                         input logic [3:0] be, input logic [31:0] exp_wd);
        push_bus(name, 1'b1, a, be, exp_wd, dly, 32'h0BAD_0BAD, 0, 0, 0);
        push_resp(name, 1'b0, '0, 1'b0, 1'b0);
        do_op(name, rd, 1'b1, f3, a, d, dly + 3);
    endtask

    task automatic bad(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a);
        push_resp(name, 1'b0, '0, 1'b1, 1'b0);
        do_op(name, rd, wr, f3, a, 32'hFFFF_FFFF, 2);
    endtask

    // Response monitor
    initial begin : monitor
        bit    prev;
        resp_t r;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 0;
            end else begin
                if (prev && !bus.lsu_stall) begin
                    if (resp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL resp_unexpected: stall released with no op outstanding");
                    end else begin
                        r = resp_q.pop_front();
                        check({r.name, ".ld_valid"}, 32'(bus.ld_valid), 32'(r.ld_valid));
                        check({r.name, ".ld_data"}, bus.ld_data, r.ld_data);
                        check({r.name, ".exc_misalign"}, 32'(bus.exc_misalign), 32'(r.exc_mis));
                        check({r.name, ".exc_bus"}, 32'(bus.exc_bus), 32'(r.exc_bus));
                    end
                end else begin
                    check("quiet_pulses", {29'b0, bus.ld_valid, bus.exc_misalign, bus.exc_bus}, 32'd0);
                    check("quiet_ld_data", bus.ld_data, 32'd0);
                end
                prev = bus.lsu_stall;
            end
        end
    end

    // Memory responder
    initial begin : responder
        bus_t        b;
        bit          active, acked, chk;
        int unsigned ack_wait, req_cyc;
        active = 0; acked = 0; chk = 0; ack_wait = 0; req_cyc = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!reset_n) begin
                if (active && !b.abort) begin
                    n_checks++; n_fail++;
                    $display("FAIL %s.reset_abort: transfer cut by reset, required completion", b.name);
                end
                active = 0;
            end else if (bus.mem_req) begin
                if (!active) begin
                    active = 1; acked = 0; req_cyc = 0;
                    if (bus_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL req_unexpected: mem_req=1 addr=0x%08h, required no request", bus.mem_addr);
                        chk = 0; b.name = "unexpected"; b.no_ack = 1; b.late_ack = 0; b.abort = 1; b.delay = 0;
                    end else begin
                        b = bus_q.pop_front();
                        chk = 1;
                    end
                    ack_wait = b.delay;
                end
                req_cyc++;
                if (chk) begin
                    check({b.name, ".mem_addr"}, bus.mem_addr, b.addr);
                    check({b.name, ".mem_be"}, 32'(bus.mem_be), 32'(b.be));
                    check({b.name, ".mem_we"}, 32'(bus.mem_we), 32'(b.we));
                    if (b.chk_wdata) check({b.name, ".mem_wdata"}, bus.mem_wdata, b.wdata);
                    check({b.name, ".req_after_ack"}, 32'(acked), 32'd0);
                end
                if (!b.no_ack && !acked) begin
                    if (ack_wait == 0) begin
                        bus.mem_ack = 1'b1; bus.mem_rdata = b.rdata; acked = 1;
                    end else begin
                        ack_wait--;
                    end
                end
            end else if (active) begin
                if (b.no_ack) begin
                    if (chk && !b.abort) check({b.name, ".req_cycles"}, req_cyc, TO);
                    if (b.late_ack) begin
                        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
                    end
                end else begin
                    check({b.name, ".acked_before_drop"}, 32'(acked), 32'd1);
                end
                active = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
        bus.ex_funct3 = '0; bus.ex_addr = '0; bus.ex_wdata = '0;
        reset_n = 1'b0;
        #12;
        check("rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst.lsu_stall", 32'(bus.lsu_stall), 32'd0);
        check("rst.pulses", {29'b0, bus.ld_valid, bus.exc_misalign, bus.exc_bus}, 32'd0);
        check("rst.ld_data", bus.ld_data, 32'd0);
        check("rst.mem_bus", {27'b0, bus.mem_we, bus.mem_be}, 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk); #2 reset_n = 1'b1;

        load("LW_100", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
        load("LB_103", 3'b000, 32'h0000_0103, 32'h8012_3456, 0, 4'b1000, 32'hFFFF_FF80);
        load("LBU_103", 3'b100, 32'h0000_0103, 32'h8012_3456, 1, 4'b1000, 32'h0000_0080);
        load("LH_102", 3'b001, 32'h0000_0102, 32'h8001_1234, 0, 4'b1100, 32'hFFFF_8001);
        load("LHU_100", 3'b101, 32'h0000_0100, 32'h7FFF_8001, 2, 4'b0011, 32'h0000_8001);
        load("LB_101", 3'b000, 32'h0000_0101, 32'h0000_7F00, 0, 4'b0010, 32'h0000_007F);
        load("LH_100", 3'b001, 32'h0000_0100, 32'h0000_FFFE, 3, 4'b0011, 32'hFFFF_FFFE);

        store("SB_201", 1'b0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 2, 4'b0010, 32'hABAB_ABAB);
        store("SH_202", 1'b0, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 1, 4'b1100, 32'hCDEF_CDEF);
        store("SW_204", 1'b0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);
        store("RW_SW_300", 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344);

        bad("SH_203_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0203);
        bad("LW_102_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
        bad("LH_101_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0101);
        bad("L_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        bad("S_f3_110", 1'b0, 1'b1, 3'b110, 32'h0000_0100);

        push_bus("LW_timeout", 1'b0, 32'h0000_0400, 4'b1111, '0, 0, '0, 1, 1, 0);
        push_resp("LW_timeout", 1'b0, '0, 1'b0, 1'b1);
        do_op("LW_timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0400, '0, TO + 2);
        @(posedge clk); #1 bus.ex_valid = 1'b0;
        repeat (3) @(posedge clk);

        load("LW_ack_at_expiry", 3'b010, 32'h0000_0404, 32'h0F0F_1234, TO - 1, 4'b1111, 32'h0F0F_1234);

        push_bus("LW_reset", 1'b0, 32'h0000_0500, 4'b1111, '0, 0, '0, 1, 0, 1);
        @(posedge clk); #1;
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b0;
        bus.ex_funct3 = 3'b010; bus.ex_addr = 32'h0000_0500;
        repeat (4) @(negedge clk);
        check("rst_mid.pre_mem_req", 32'(bus.mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        bus.ex_valid = 1'b0;
        #1;
        check("rst_mid.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid.lsu_stall", 32'(bus.lsu_stall), 32'd0);
        check("rst_mid.pulses", {29'b0, bus.ld_valid, bus.exc_misalign, bus.exc_bus}, 32'd0);
        check("rst_mid.mem_bus", {27'b0, bus.mem_we, bus.mem_be}, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        load("LW_after_reset", 3'b010, 32'h0000_0104, 32'h0123_4567, 0, 4'b1111, 32'h0123_4567);

        @(posedge clk); #1 bus.ex_valid = 1'b0;
        repeat (5) @(posedge clk);
        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
